udp_axil_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank for the UDP IP's control plane. It is the successor to the fixed four-register S00_AXI slave. It adds:
- configurable width and register counts;
- byte-strobe writes;
- read-only status registers;
- a self-clearing pulse register;
- SLVERR on unmapped or illegal accesses.

It sits between the block-design AXI interconnect and the UDP datapath, which consumes `ctrl_o`/`pulse_o` and drives `stat_i`.

---
 rtl/udp_axil_regbank.sv | 206 ++++++++++++++++++++
 tb/tb_udp_axil_regbank.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/udp_axil_regbank.sv
// AXI4-Lite slave register bank for the UDP control plane: byte-strobed control
// registers, read-only status inputs, a self-clearing pulse register and SLVERR decode.
module udp_axil_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_NUM_CTRL         = 8,
    parameter int C_NUM_STAT         = 4,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_CTRL_RESET = {C_S_AXI_DATA_WIDTH{1'b0}}
) (
    input  logic                                     s00_axi_aclk,
    input  logic                                     s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s00_axi_awaddr,
    input  logic [2:0]                               s00_axi_awprot,
    input  logic                                     s00_axi_awvalid,
    output logic                                     s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          s00_axi_wstrb,
    input  logic                                     s00_axi_wvalid,
    output logic                                     s00_axi_wready,
    output logic [1:0]                               s00_axi_bresp,
    output logic                                     s00_axi_bvalid,
    input  logic                                     s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s00_axi_araddr,
    input  logic [2:0]                               s00_axi_arprot,
    input  logic                                     s00_axi_arvalid,
    output logic                                     s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            s00_axi_rdata,
    output logic [1:0]                               s00_axi_rresp,
    output logic                                     s00_axi_rvalid,
    input  logic                                     s00_axi_rready,
    output logic [C_NUM_CTRL*C_S_AXI_DATA_WIDTH-1:0] ctrl_o,
    input  logic [C_NUM_STAT*C_S_AXI_DATA_WIDTH-1:0] stat_i,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            pulse_o,
    output logic [C_NUM_CTRL-1:0]                    ctrl_wr_o
);
    localparam int W  = C_S_AXI_DATA_WIDTH;
    localparam int A  = C_S_AXI_ADDR_WIDTH;
    localparam int SW = W / 8;
    localparam int L  = $clog2(SW);
    localparam int IW = A - L;
    localparam logic [31:0] CTRL_END = 32'(C_NUM_CTRL);
    localparam logic [31:0] P_IDX    = 32'(C_NUM_CTRL + C_NUM_STAT);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    function automatic logic [W-1:0] strb_mask(input logic [SW-1:0] strb);
        logic [W-1:0] m;
        for (int j = 0; j < SW; j++) begin
            m[j*8 +: 8] = {8{strb[j]}};
        end
        return m;
    endfunction

    logic               aw_full_r, w_full_r, awready_r, wready_r;
    logic [IW-1:0]      aw_idx_r;
    logic [W-1:0]       wdata_r;
    logic [SW-1:0]      wstrb_r;
    logic               bvalid_r;
    logic [1:0]         bresp_r;
    logic [C_NUM_CTRL*W-1:0] ctrl_r;
    logic [C_NUM_CTRL-1:0]   ctrl_wr_r;
    logic [W-1:0]       pulse_r;
    logic               arready_r, rvalid_r;
    logic [W-1:0]       rdata_r;
    logic [1:0]         rresp_r;

    logic               aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic               aw_full_next_s, w_full_next_s, rvalid_next_s;
    logic [31:0]        aw_idx32_s, ar_idx32_s;
    logic [W-1:0]       wr_mask_s;
    logic [C_NUM_CTRL*W-1:0] ctrl_next_s;
    logic [C_NUM_CTRL-1:0]   ctrl_wr_next_s;
    logic [W-1:0]       pulse_next_s;
    logic               bvalid_next_s;
    logic [1:0]         bresp_next_s;
    logic [W-1:0]       rd_data_s;
    logic [1:0]         rd_resp_s;
    logic               unused_s;

    assign aw_hs_s    = s00_axi_awvalid & awready_r;
    assign w_hs_s     = s00_axi_wvalid & wready_r;
    assign ar_hs_s    = s00_axi_arvalid & arready_r;
    // A commit waits for a pending B response so the response is never overwritten.
    assign commit_s   = aw_full_r & w_full_r & ~bvalid_r;
    assign aw_full_next_s = (aw_full_r & ~commit_s) | aw_hs_s;
    assign w_full_next_s  = (w_full_r & ~commit_s) | w_hs_s;
    assign rvalid_next_s  = (rvalid_r & ~s00_axi_rready) | ar_hs_s;
    assign aw_idx32_s = 32'(aw_idx_r);
    assign ar_idx32_s = 32'(s00_axi_araddr[A-1:L]);
    assign wr_mask_s  = strb_mask(wstrb_r);
    assign unused_s   = ^{s00_axi_awprot, s00_axi_arprot,
                          s00_axi_awaddr[L-1:0], s00_axi_araddr[L-1:0]};

    // Write commit: register merge, strobe flags, pulse and B response.
    always_comb begin
        ctrl_next_s    = ctrl_r;
        ctrl_wr_next_s = {C_NUM_CTRL{1'b0}};
        pulse_next_s   = {W{1'b0}};
        bvalid_next_s  = bvalid_r;
        bresp_next_s   = bresp_r;
        if (commit_s) begin
            bvalid_next_s = 1'b1;
            if (aw_idx32_s < CTRL_END) begin
                bresp_next_s = RESP_OKAY;
                for (int i = 0; i < C_NUM_CTRL; i++) begin
                    ctrl_wr_next_s[i]  = (aw_idx32_s == 32'(i));
                    ctrl_next_s[i*W +: W] = ctrl_wr_next_s[i] ?
                        ((ctrl_r[i*W +: W] & ~wr_mask_s) | (wdata_r & wr_mask_s)) :
                        ctrl_r[i*W +: W];
                end
            end else if (aw_idx32_s == P_IDX) begin
                bresp_next_s = RESP_OKAY;
                pulse_next_s = wdata_r & wr_mask_s;
            end else begin
                bresp_next_s = RESP_SLVERR;
            end
        end else if (bvalid_r && s00_axi_bready) begin
            bvalid_next_s = 1'b0;
        end else begin
            bvalid_next_s = bvalid_r;
        end
    end

    // Read decode: control value, status slice, or zero for pulse/unmapped.
    always_comb begin
        rd_data_s = {W{1'b0}};
        rd_resp_s = RESP_OKAY;
        if (ar_idx32_s < CTRL_END) begin
            for (int i = 0; i < C_NUM_CTRL; i++) begin
                rd_data_s = (ar_idx32_s == 32'(i)) ? ctrl_r[i*W +: W] : rd_data_s;
            end
        end else if (ar_idx32_s < P_IDX) begin
            for (int i = 0; i < C_NUM_STAT; i++) begin
                rd_data_s = (ar_idx32_s == CTRL_END + 32'(i)) ? stat_i[i*W +: W] : rd_data_s;
            end
        end else if (ar_idx32_s == P_IDX) begin
            rd_resp_s = RESP_OKAY;
        end else begin
            rd_resp_s = RESP_SLVERR;
        end
    end

    // Write-path state: holding buffers, readies, registers and B channel.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            aw_full_r <= 1'b0;
            w_full_r  <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            aw_idx_r  <= {IW{1'b0}};
            wdata_r   <= {W{1'b0}};
            wstrb_r   <= {SW{1'b0}};
            ctrl_r    <= {C_NUM_CTRL{C_CTRL_RESET}};
            ctrl_wr_r <= {C_NUM_CTRL{1'b0}};
            pulse_r   <= {W{1'b0}};
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
        end else begin
            aw_full_r <= aw_full_next_s;
            w_full_r  <= w_full_next_s;
            awready_r <= ~aw_full_next_s;
            wready_r  <= ~w_full_next_s;
            if (aw_hs_s) begin
                aw_idx_r <= s00_axi_awaddr[A-1:L];
            end
            if (w_hs_s) begin
                wdata_r <= s00_axi_wdata;
                wstrb_r <= s00_axi_wstrb;
            end
            ctrl_r    <= ctrl_next_s;
            ctrl_wr_r <= ctrl_wr_next_s;
            pulse_r   <= pulse_next_s;
            bvalid_r  <= bvalid_next_s;
            bresp_r   <= bresp_next_s;
        end
    end

    // Read-path state: AR acceptance and held R channel.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= {W{1'b0}};
            rresp_r   <= 2'b00;
        end else begin
            arready_r <= ~rvalid_next_s;
            rvalid_r  <= rvalid_next_s;
            if (ar_hs_s) begin
                rdata_r <= rd_data_s;
                rresp_r <= rd_resp_s;
            end
        end
    end

    assign s00_axi_awready = awready_r;
    assign s00_axi_wready  = wready_r;
    assign s00_axi_bvalid  = bvalid_r;
    assign s00_axi_bresp   = bresp_r;
    assign s00_axi_arready = arready_r;
    assign s00_axi_rvalid  = rvalid_r;
    assign s00_axi_rdata   = rdata_r;
    assign s00_axi_rresp   = rresp_r;
    assign ctrl_o          = ctrl_r;
    assign ctrl_wr_o       = ctrl_wr_r;
    assign pulse_o         = pulse_r;
endmodule

// File: tb/tb_udp_axil_regbank.sv
// Directed bench for udp_axil_regbank: vector table plus hand-written handshake sequences.
module tb_udp_axil_regbank;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic         aresetn;
    logic [5:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata, pulse;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [255:0] ctrl;
    logic [127:0] stat;
    logic [7:0]   ctrl_wr;

    udp_axil_regbank dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready), .ctrl_o(ctrl), .stat_i(stat), .pulse_o(pulse),
        .ctrl_wr_o(ctrl_wr)
    );

    int errors = 0;
    int checks = 0;
    int wr_cnt[8];
    int pulse_cycles;
    logic [31:0] pulse_seen;

    typedef struct {
        bit          is_wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t vecs[$];

    always @(negedge clk) begin
        for (int i = 0; i < 8; i++) if (ctrl_wr[i]) wr_cnt[i]++;
        if (pulse != 32'h0) begin
            pulse_cycles++;
            pulse_seen = pulse;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        bit aw_done, w_done, aw_now, w_now;
        int cnt;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; cnt = 0; resp = 2'b11;
        while (!(aw_done && w_done) && cnt < 40) begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            @(negedge clk); cnt++;
            if (aw_now) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_now)  begin wvalid = 1'b0;  w_done = 1'b1;  end
        end
        while (!bvalid && cnt < 40) begin @(negedge clk); cnt++; end
        if (cnt >= 40) begin
            checks++; errors++;
            $display("FAIL write_timeout: addr %h no response after %0d cycles", a, cnt);
        end else begin
            resp = bresp;
        end
        @(negedge clk);
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        int cnt;
        araddr = a; arvalid = 1'b1; rready = 1'b1; cnt = 0; d = 32'hx; resp = 2'b11;
        while (!arready && cnt < 40) begin @(negedge clk); cnt++; end
        @(negedge clk);
        arvalid = 1'b0;
        while (!rvalid && cnt < 40) begin @(negedge clk); cnt++; end
        if (cnt >= 40) begin
            checks++; errors++;
            $display("FAIL read_timeout: addr %h no data after %0d cycles", a, cnt);
        end else begin
            d = rdata; resp = rresp;
        end
        @(negedge clk);
        rready = 1'b0;
    endtask

    function automatic void add(input bit w, input logic [5:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] ed, input logic [1:0] er);
        vec_t v;
        v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.exp_data = ed; v.exp_resp = er;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        aresetn = 1'b0; awaddr = 6'h0; araddr = 6'h0; awprot = 3'h0; arprot = 3'h0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = 32'h0; wstrb = 4'h0;
        stat = {32'hCAFEF00D, 32'h0BADC0DE, 32'h12345678, 32'hDEADBEEF};
        pulse_cycles = 0; pulse_seen = 32'h0;
        for (int i = 0; i < 8; i++) wr_cnt[i] = 0;

        // Reset state and first post-reset edge
        repeat (3) @(negedge clk);
        check("rst_readies", {61'h0, awready, wready, arready}, 64'h0);
        check("rst_valids", {62'h0, bvalid, rvalid}, 64'h0);
        check("rst_ctrl_lo", {32'h0, ctrl[31:0]}, 64'h0);
        check("rst_pulse_wr", {24'h0, pulse, ctrl_wr}, 64'h0);
        aresetn = 1'b1;
        @(negedge clk);
        check("post_rst_readies", {61'h0, awready, wready, arready}, 64'h7);
        do_read(6'h00, rd, rs);
        check("rst_read_data", {32'h0, rd}, 64'h0);
        check("rst_read_resp", {62'h0, rs}, 64'h0);

        // Table of single transactions
        for (int i = 0; i < 8; i++) add(1'b1, 6'(i * 4), 32'(i + 1), 4'hF, 32'h0, 2'b00);
        for (int i = 0; i < 8; i++) add(1'b0, 6'(i * 4), 32'h0, 4'h0, 32'(i + 1), 2'b00);
        add(1'b1, 6'h04, 32'hAABBCCDD, 4'hF, 32'h0, 2'b00);
        add(1'b1, 6'h04, 32'h11223344, 4'h5, 32'h0, 2'b00);
        add(1'b0, 6'h04, 32'h0, 4'h0, 32'hAA22CC44, 2'b00);
        add(1'b0, 6'h0B, 32'h0, 4'h0, 32'h00000003, 2'b00);
        add(1'b0, 6'h20, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00);
        add(1'b1, 6'h20, 32'h55555555, 4'hF, 32'h0, 2'b10);
        add(1'b0, 6'h20, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00);
        add(1'b0, 6'h24, 32'h0, 4'h0, 32'h12345678, 2'b00);
        add(1'b0, 6'h3C, 32'h0, 4'h0, 32'h00000000, 2'b10);
        add(1'b1, 6'h3C, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b10);
        add(1'b0, 6'h34, 32'h0, 4'h0, 32'h00000000, 2'b10);
        add(1'b0, 6'h30, 32'h0, 4'h0, 32'h00000000, 2'b00);
        for (int i = 0; i < 8; i++) wr_cnt[i] = 0;
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
                check($sformatf("vec%0d_bresp", i), {62'h0, rs}, {62'h0, vecs[i].exp_resp});
            end else begin
                do_read(vecs[i].addr, rd, rs);
                check($sformatf("vec%0d_rdata", i), {32'h0, rd}, {32'h0, vecs[i].exp_data});
                check($sformatf("vec%0d_rresp", i), {62'h0, rs}, {62'h0, vecs[i].exp_resp});
            end
        end
        for (int i = 0; i < 8; i++)
            check($sformatf("ctrl_wr_count%0d", i), 64'(wr_cnt[i]), (i == 1) ? 64'd3 : 64'd1);
        check("ctrl_o_idx1", {32'h0, ctrl[63:32]}, 64'hAA22CC44);
        check("ctrl_o_idx7", {32'h0, ctrl[255:224]}, 64'h8);

        // W leads AW by 3 cycles; then B held off to block the next commit
        wdata = 32'h000000A5; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("aw_ready_idle", {63'h0, awready}, 64'h1);
        awaddr = 6'h0C; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("bvalid_before", {63'h0, bvalid}, 64'h0);
        @(negedge clk);
        check("bvalid_after1", {63'h0, bvalid}, 64'h1);
        check("ctrl3_first", {32'h0, ctrl[127:96]}, 64'hA5);
        check("ctrl_wr_first", {56'h0, ctrl_wr}, 64'h08);
        wdata = 32'h5A5A5A5A; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d_b", i), {61'h0, bvalid, bresp}, 64'h4);
            check($sformatf("hold%0d_ctrl3", i), {32'h0, ctrl[127:96]}, 64'hA5);
            check($sformatf("hold%0d_awready", i), {63'h0, awready}, 64'h0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("b_released", {63'h0, bvalid}, 64'h0);
        @(negedge clk);
        check("second_commit_b", {63'h0, bvalid}, 64'h1);
        check("second_commit_ctrl3", {32'h0, ctrl[127:96]}, 64'h5A5A5A5A);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;

        // Pulse register, full strobe then single-byte strobe
        pulse_cycles = 0; pulse_seen = 32'h0;
        do_write(6'h30, 32'h00000081, 4'hF, rs);
        repeat (2) @(negedge clk);
        check("pulse_resp", {62'h0, rs}, 64'h0);
        check("pulse_cycles", 64'(pulse_cycles), 64'd1);
        check("pulse_value", {32'h0, pulse_seen}, 64'h81);
        pulse_cycles = 0; pulse_seen = 32'h0;
        do_write(6'h30, 32'hFFFFFF81, 4'h1, rs);
        repeat (2) @(negedge clk);
        check("pulse_strb_cycles", 64'(pulse_cycles), 64'd1);
        check("pulse_strb_value", {32'h0, pulse_seen}, 64'h81);

        // Reset while a write response is pending
        awaddr = 6'h00; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_bvalid", {63'h0, bvalid}, 64'h1);
        check("pre_rst_ctrl0", {32'h0, ctrl[31:0]}, 64'h77);
        aresetn = 1'b0;
        @(negedge clk);
        check("mid_rst_bvalid", {63'h0, bvalid}, 64'h0);
        check("mid_rst_ctrl0", {32'h0, ctrl[31:0]}, 64'h0);
        check("mid_rst_awready", {63'h0, awready}, 64'h0);
        aresetn = 1'b1;
        @(negedge clk);
        check("rerst_awready", {63'h0, awready}, 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
